// File: rtl/wb_pkg.sv
// Shared Wishbone slave definitions: bus widths, slave FSM states and the
// captured-request record used by the Wishbone slaves of the SoC.
package wb_pkg;

  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_slv_state_e;

  // Byte-offset bits [1:0] are never used, so only the word address is kept
  typedef struct packed {
    logic [WB_DW-1:2]   adr;
    logic               we;
    logic [WB_SELW-1:0] sel;
    logic [WB_DW-1:0]   dat;
  } wb_req_t;

endpackage

// File: rtl/wb_ram_bank.sv
// Synchronous single-port word RAM with per-byte-lane write enables.
// Read data is registered and shows the contents from before a same-edge write.
module wb_ram_bank
  import wb_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic               i_clk,
  input  logic [AW-1:0]      i_addr,
  input  logic               i_we,
  input  logic [WB_SELW-1:0] i_sel,
  input  logic [WB_DW-1:0]   i_wdata,
  output logic [WB_DW-1:0]   o_rdata
);

  logic [WB_DW-1:0] r_mem [2**AW];
  logic [WB_DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int k = 0; k < WB_SELW; k++) begin
        if (i_sel[k]) begin
          r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
        end
      end
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic slave in front of a local word RAM, with a fixed number of
// wait states before the single-cycle ack/err response.
module wb_ram_slave
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wb_cyc,
  input  logic               i_wb_stb,
  input  logic               i_wb_we,
  input  logic [WB_DW-1:0]   i_wb_adr,
  input  logic [WB_SELW-1:0] i_wb_sel,
  input  logic [WB_DW-1:0]   i_wb_dat,
  output logic [WB_DW-1:0]   o_wb_dat,
  output logic               o_wb_ack,
  output logic               o_wb_err
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  wb_slv_state_e          r_state;
  logic [3:0]             r_cnt;
  wb_req_t                r_req;
  logic                   r_ack;
  logic                   r_err;
  logic                   r_rd_en;
  logic                   w_in_range;
  logic                   w_ram_we;
  logic [ADDR_WIDTH-1:0]  w_ram_addr;
  logic [WB_DW-1:0]       w_ram_rdata;

  assign w_in_range = (r_req.adr[WB_DW-1:ADDR_WIDTH+2] == '0);
  assign w_ram_addr = r_req.adr[ADDR_WIDTH+1:2];
  // The write commits on the same edge that raises ack
  assign w_ram_we   = (r_state == RESP) && r_req.we && w_in_range;

  wb_ram_bank #(
    .AW (ADDR_WIDTH)
  ) u_bank (
    .i_clk   (i_clk),
    .i_addr  (w_ram_addr),
    .i_we    (w_ram_we),
    .i_sel   (r_req.sel),
    .i_wdata (r_req.dat),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_req   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rd_en <= 1'b0;
    end else begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rd_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_wb_cyc && i_wb_stb) begin
            r_req.adr <= i_wb_adr[WB_DW-1:2];
            r_req.we  <= i_wb_we;
            r_req.sel <= i_wb_sel;
            r_req.dat <= i_wb_dat;
            r_cnt     <= WAIT_LOAD;
            r_state   <= (WAIT_CYCLES > 0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          if (!i_wb_cyc) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
          end else if (r_cnt == 4'd0) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_ack   <= w_in_range;
          r_err   <= !w_in_range;
          r_rd_en <= w_in_range && !r_req.we;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM read data is already registered; r_rd_en only gates it to zero
  assign o_wb_dat = r_rd_en ? w_ram_rdata : '0;
  assign o_wb_ack = r_ack;
  assign o_wb_err = r_err;

endmodule
